// File: rtl/mtr_ramp_ctrl.sv
// rtl/mtr_ramp_ctrl.sv - dual-side motor speed ramp controller with emergency stop
//
// Purpose:
//   Accepts left/right target speeds and slews the registered motor speeds
//   toward them by STEP once every TICK_DIV clocks. An emergency stop
//   overrides everything, clears the targets and slews both sides to zero
//   at 4*STEP per tick.
//
// Build option:
//   MTR_RAMP_CLAMP_EN - when defined, captured targets saturate to +/-MAX_SPD.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   cmd_vld   in   1   target command present
//   cmd_rdy   out  1   command can be accepted (low in ESTOP)
//   tgt_lft   in  11   signed left target speed
//   tgt_rght  in  11   signed right target speed
//   estop     in   1   level-sensitive emergency stop
//   lft_spd   out 11   registered signed left speed
//   rght_spd  out 11   registered signed right speed
//   ramping   out  1   high in RAMP or ESTOP
//   at_tgt    out  1   high in IDLE with both speeds on target
module mtr_ramp_ctrl #(
  parameter int STEP     = 8,
  parameter int TICK_DIV = 512,
  parameter int MAX_SPD  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [10:0] tgt_lft,
  input  logic [10:0] tgt_rght,
  input  logic        estop,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        ramping,
  output logic        at_tgt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RAMP  = 2'd1;
  localparam logic [1:0] ESTOP = 2'd2;

  localparam int              CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [11:0] RAMP_MAG = 12'(STEP);
  localparam logic signed [11:0] STOP_MAG = 12'(4 * STEP);

  // Elaboration-time guard on the parameter ranges the design is built for.
  if (TICK_DIV < 2 || TICK_DIV > 4096) begin : gBadTickDiv
    $error("mtr_ramp_ctrl: TICK_DIV out of range 2..4096");
  end
  if (MAX_SPD < 1 || MAX_SPD > 1023) begin : gBadMaxSpd
    $error("mtr_ramp_ctrl: MAX_SPD out of range 1..1023");
  end

  // One slew step: 12-bit signed math so the widest difference (-2047)
  // fits, and the result never overshoots the target, so it cannot wrap.
  function automatic logic [10:0] stepToward(input logic [10:0] cur,
                                             input logic [10:0] tgt,
                                             input logic signed [11:0] mag);
    logic signed [11:0] curW, tgtW, diff, absDiff;
    curW    = {cur[10], cur};
    tgtW    = {tgt[10], tgt};
    diff    = tgtW - curW;
    absDiff = (diff < 0) ? -diff : diff;
    if (absDiff <= mag)
      return tgt;
    else if (diff < 0)
      return 11'(curW - mag);
    else
      return 11'(curW + mag);
  endfunction

`ifdef MTR_RAMP_CLAMP_EN
  localparam logic signed [11:0] MAX_W = 12'(MAX_SPD);
  function automatic logic [10:0] capTgt(input logic [10:0] t);
    logic signed [11:0] w;
    w = {t[10], t};
    if (w > MAX_W)
      return MAX_W[10:0];
    else if (w < -MAX_W)
      return 11'(-MAX_W);
    else
      return t;
  endfunction
`else
  function automatic logic [10:0] capTgt(input logic [10:0] t);
    return t;
  endfunction
`endif

  logic [1:0]    state, nextState;
  logic [CW-1:0] tickCnt;
  logic [10:0]   tgtLft, tgtRght;
  logic [10:0]   capLft, capRght, nextTgtLft, nextTgtRght;
  logic [10:0]   stepLft, stepRght, nextLft, nextRght;
  logic          cmdAccept, tickEnd, isStep;

  assign cmd_rdy = (state != ESTOP);
  assign ramping = (state == RAMP) || (state == ESTOP);
  assign at_tgt  = (state == IDLE) && (lft_spd == tgtLft) && (rght_spd == tgtRght);

  // estop on the same edge cancels the command.
  assign cmdAccept   = cmd_vld && cmd_rdy && !estop;
  assign capLft      = capTgt(tgt_lft);
  assign capRght     = capTgt(tgt_rght);
  assign nextTgtLft  = cmdAccept ? capLft  : tgtLft;
  assign nextTgtRght = cmdAccept ? capRght : tgtRght;

  assign tickEnd  = (tickCnt == CNT_LAST);
  assign isStep   = (state != IDLE) && tickEnd;
  assign stepLft  = (state == ESTOP) ? stepToward(lft_spd,  11'd0, STOP_MAG)
                                     : stepToward(lft_spd,  tgtLft,  RAMP_MAG);
  assign stepRght = (state == ESTOP) ? stepToward(rght_spd, 11'd0, STOP_MAG)
                                     : stepToward(rght_spd, tgtRght, RAMP_MAG);
  assign nextLft  = isStep ? stepLft  : lft_spd;
  assign nextRght = isStep ? stepRght : rght_spd;

  always_comb begin
    nextState = state;
    if (estop) begin
      nextState = ESTOP;
    end else begin
      case (state)
        IDLE:
          if (cmdAccept && (capLft != lft_spd || capRght != rght_spd))
            nextState = RAMP;
        RAMP:
          // Done is judged against a target replaced on this same edge.
          if (isStep && nextLft == nextTgtLft && nextRght == nextTgtRght)
            nextState = IDLE;
        ESTOP:
          if (lft_spd == 11'd0 && rght_spd == 11'd0)
            nextState = IDLE;
        default:
          nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tickCnt  <= '0;
      tgtLft   <= '0;
      tgtRght  <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      state <= nextState;
      // Held at zero through IDLE so the first step lands TICK_DIV clocks
      // after acceptance; a retarget in RAMP leaves the phase untouched.
      if (state == IDLE || nextState == IDLE)
        tickCnt <= '0;
      else if (tickEnd)
        tickCnt <= '0;
      else
        tickCnt <= CW'(tickCnt + 1'b1);
      if (estop) begin
        tgtLft  <= '0;
        tgtRght <= '0;
      end else if (cmdAccept) begin
        tgtLft  <= capLft;
        tgtRght <= capRght;
      end
      lft_spd  <= nextLft;
      rght_spd <= nextRght;
    end
  end

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// tb/tb_mtr_ramp_ctrl.sv - self-checking scoreboard bench for mtr_ramp_ctrl
module tb_mtr_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        estop = 1'b0;
  logic [10:0] tgt_lft = '0;
  logic [10:0] tgt_rght = '0;
  logic        cmd_rdy, ramping, at_tgt;
  logic [10:0] lft_spd, rght_spd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int l;
    int r;
  } exp_t;
  exp_t sbq[$];

  mtr_ramp_ctrl #(.STEP(8), .TICK_DIV(4), .MAX_SPD(1000)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .tgt_lft(tgt_lft), .tgt_rght(tgt_rght), .estop(estop),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .ramping(ramping), .at_tgt(at_tgt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference slew: move toward tgt by mag, landing exactly when within mag.
  function automatic int mdl(int cur, int tgt, int mag);
    if (tgt > cur) return (tgt - cur <= mag) ? tgt : cur + mag;
    else           return (cur - tgt <= mag) ? tgt : cur - mag;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic acceptCmd(int l, int r);
    @(negedge clk);
    cmd_vld = 1'b1; tgt_lft = 11'(l); tgt_rght = 11'(r);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (lft_spd !== 11'd0) begin failures++; $display("FAIL reset_lft got=%0d exp=0", lft_spd); end
    checks++; if (rght_spd !== 11'd0) begin failures++; $display("FAIL reset_rght got=%0d exp=0", rght_spd); end
    checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL reset_ramping got=%b exp=0", ramping); end
    checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL reset_at_tgt got=%b exp=1", at_tgt); end
    checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
  endtask

  task automatic test_ramp_basic();
    int l, r, gl, gr;
    exp_t e;
    doReset();
    l = 0; r = 0;
    for (int s = 0; s < 3; s++) begin
      l = mdl(l, 20, 8); r = mdl(r, -20, 8);
      sbq.push_back('{l: l, r: r});
    end
    acceptCmd(20, -20);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      gl = $signed(lft_spd); gr = $signed(rght_spd);
      if (k == 3) begin
        checks++; if (gl !== 0) begin failures++; $display("FAIL basic_early k=3 got=%0d exp=0", gl); end
      end
      if (k % 4 == 0) begin
        e = sbq.pop_front();
        checks++; if (gl !== e.l) begin failures++; $display("FAIL basic_lft k=%0d got=%0d exp=%0d", k, gl, e.l); end
        checks++; if (gr !== e.r) begin failures++; $display("FAIL basic_rght k=%0d got=%0d exp=%0d", k, gr, e.r); end
      end
    end
    checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL basic_at_tgt got=%b exp=1", at_tgt); end
    checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL basic_idle ramping got=%b exp=0", ramping); end
  endtask

  task automatic test_retarget();
    int l, gl;
    exp_t e;
    doReset();
    l = 0;
    for (int k = 4; k <= 40; k += 4) begin
      l = mdl(l, (k < 22) ? 100 : 0, 8);
      sbq.push_back('{l: l, r: l});
    end
    acceptCmd(100, 100);
    for (int k = 1; k <= 40; k++) begin
      if (k == 22) begin
        @(negedge clk);
        cmd_vld = 1'b1; tgt_lft = 11'd0; tgt_rght = 11'd0;
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      gl = $signed(lft_spd);
      if (k == 21) begin
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL retarget_rdy got=%b exp=1", cmd_rdy); end
      end
      if (k % 4 == 0) begin
        e = sbq.pop_front();
        checks++; if (gl !== e.l) begin failures++; $display("FAIL retarget_lft k=%0d got=%0d exp=%0d", k, gl, e.l); end
      end
    end
    checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL retarget_at_tgt got=%b exp=1", at_tgt); end
  endtask

  task automatic test_estop();
    int l, gl, gr;
    exp_t e;
    doReset();
    l = 0;
    for (int k = 4; k <= 72; k += 4) begin
      if (k <= 32) l = mdl(l, 100, 8);
      else         l = mdl(l, 0, 32);
      sbq.push_back('{l: l, r: l});
    end
    acceptCmd(100, 100);
    for (int k = 1; k <= 73; k++) begin
      if (k == 33) begin @(negedge clk); estop = 1'b1; end
      if (k == 73) begin @(negedge clk); estop = 1'b0; end
      @(posedge clk); #1;
      gl = $signed(lft_spd); gr = $signed(rght_spd);
      if (k % 4 == 0 && k <= 72) begin
        e = sbq.pop_front();
        checks++; if (gl !== e.l) begin failures++; $display("FAIL estop_lft k=%0d got=%0d exp=%0d", k, gl, e.l); end
        checks++; if (gr !== e.r) begin failures++; $display("FAIL estop_rght k=%0d got=%0d exp=%0d", k, gr, e.r); end
      end
      if (k == 34) begin
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL estop_cmd_rdy got=%b exp=0", cmd_rdy); end
      end
      if (k == 72) begin
        checks++; if (ramping !== 1'b1) begin failures++; $display("FAIL estop_hold ramping got=%b exp=1", ramping); end
      end
      if (k == 73) begin
        checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL estop_exit ramping got=%b exp=0", ramping); end
        checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL estop_exit at_tgt got=%b exp=1", at_tgt); end
      end
    end
  endtask

  task automatic test_clamp(output int finalExp);
    int cur, prev;
    bit mono, done;
`ifdef MTR_RAMP_CLAMP_EN
    finalExp = 1000;
`else
    finalExp = 1023;
`endif
    doReset();
    acceptCmd(1023, 0);
    prev = 0; mono = 1'b1; done = 1'b0;
    for (int k = 1; k <= 700 && !done; k++) begin
      @(posedge clk); #1;
      cur = $signed(lft_spd);
      if (cur < prev || cur - prev > 8) mono = 1'b0;
      prev = cur;
      if (!ramping) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL clamp_timeout got=%b exp=1", done); end
    checks++; if ($signed(lft_spd) !== finalExp) begin failures++; $display("FAIL clamp_final got=%0d exp=%0d", $signed(lft_spd), finalExp); end
    checks++; if (mono !== 1'b1) begin failures++; $display("FAIL clamp_monotonic got=%b exp=1", mono); end
  endtask

  task automatic test_descent(int startVal);
    int l, gl, n;
    exp_t e;
    sbq.delete();
    l = startVal;
    while (l != -1024) begin
      l = mdl(l, -1024, 8);
      sbq.push_back('{l: l, r: 0});
    end
    n = sbq.size() * 4;
    acceptCmd(-1024, 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      gl = $signed(lft_spd);
      if (k % 4 == 0) begin
        e = sbq.pop_front();
        checks++; if (gl !== e.l) begin failures++; $display("FAIL descent_lft k=%0d got=%0d exp=%0d", k, gl, e.l); end
      end
    end
    checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL descent_at_tgt got=%b exp=1", at_tgt); end
    // Reset in the middle of a fresh ramp.
    acceptCmd(500, -500);
    repeat (10) @(posedge clk);
    #1;
    checks++; if ($signed(lft_spd) !== -1008) begin failures++; $display("FAIL midrst_pre got=%0d exp=-1008", $signed(lft_spd)); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (lft_spd !== 11'd0) begin failures++; $display("FAIL midrst_lft got=%0d exp=0", $signed(lft_spd)); end
    checks++; if (rght_spd !== 11'd0) begin failures++; $display("FAIL midrst_rght got=%0d exp=0", $signed(rght_spd)); end
    checks++; if (ramping !== 1'b0) begin failures++; $display("FAIL midrst_ramping got=%b exp=0", ramping); end
    rst = 1'b0;
  endtask

  task automatic test_estop_cmd();
    bit stayed;
    doReset();
    @(negedge clk);
    cmd_vld = 1'b1; estop = 1'b1; tgt_lft = 11'd300; tgt_rght = 11'(-300);
    @(posedge clk); #1;
    checks++; if (ramping !== 1'b1) begin failures++; $display("FAIL estopcmd_state ramping got=%b exp=1", ramping); end
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL estopcmd_rdy got=%b exp=0", cmd_rdy); end
    cmd_vld = 1'b0; estop = 1'b0;
    @(posedge clk); #1;
    checks++; if (at_tgt !== 1'b1) begin failures++; $display("FAIL estopcmd_targets at_tgt got=%b exp=1", at_tgt); end
    stayed = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (lft_spd !== 11'd0 || rght_spd !== 11'd0 || ramping !== 1'b0) stayed = 1'b0;
    end
    checks++; if (stayed !== 1'b1) begin failures++; $display("FAIL estopcmd_cancel got=%b exp=1", stayed); end
  endtask

  initial begin
    int clampFinal;
    test_reset();
    test_ramp_basic();
    test_retarget();
    test_estop();
    test_clamp(clampFinal);
    test_descent(clampFinal);
    test_estop_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
